mips_mc_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and write-back. It produces all datapath enables and selects, including the 4-bit `ALUControl` code consumed by the shared ALU. It sits between the instruction register (`Op`/`Funct` fields) and the multi-cycle datapath. It also closes the loop on the ALU `Zero` flag for branches.

---
 rtl/mips_mc_pkg.sv | 38 +++
 rtl/mips_mc_control_alu_decoder.sv | 19 +
 rtl/mips_mc_control.sv | 130 +++++++++++++
 tb/tb_mips_mc_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared states, opcode/funct fields and ALU codes for the multi-cycle MIPS control.
// MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package mips_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  // Idle code: states that do not use the ALU drive ALUControl to 0000
  localparam logic [1:0] ALUOP_NONE  = 2'b11;
  function automatic logic insn_illegal(input logic [5:0] op, input logic [5:0] funct);
    logic op_ok, fn_ok;
    op_ok = op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    fn_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    return !op_ok || (op == OP_RTYPE && !fn_ok);
  endfunction
endpackage

// File: rtl/mips_mc_control_alu_decoder.sv
// alu_decoder: maps the FSM's ALUOp and the instruction Funct field to the ALU control code.
module alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control
);
  logic [3:0] funct_code;
  always_comb begin
    funct_code = funct == F_ADD ? ALU_ADD :
                 funct == F_SUB ? ALU_SUB :
                 funct == F_OR  ? ALU_OR  :
                 funct == F_SLT ? ALU_SLT : ALU_AND;
    alu_control = alu_op == ALUOP_ADD   ? ALU_ADD :
                  alu_op == ALUOP_SUB   ? ALU_SUB :
                  alu_op == ALUOP_FUNCT ? funct_code : ALU_AND;
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore FSM sequencing multi-cycle MIPS instructions and driving datapath controls.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions lock in TRAP with Illegal=1 until reset.
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUControl,
  output logic       PCEn,
  output logic       Illegal
);
  state_e state_q, state_d;
  logic [1:0] alu_op;
  logic pc_write, branch, mem_write, ir_write, reg_write, illegal;
  state_e decode_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  always_comb begin
    illegal = insn_illegal(Op, Funct);
    decode_next = (Op == OP_LW || Op == OP_SW) ? S_MEMADR :
                  Op == OP_RTYPE ? S_EXECUTE :
                  Op == OP_BEQ   ? S_BRANCH :
                  Op == OP_ADDI  ? S_ADDIEX : S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (illegal) decode_next = S_TRAP;
`else
    if (illegal) decode_next = S_FETCH;
`endif
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = decode_next;
      S_MEMADR:  state_d = Op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end
  always_comb begin
    IorD = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    reg_write = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSrc = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    alu_op = ALUOP_NONE;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        ALUSrcB = 2'b01;
        alu_op = ALUOP_ADD;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        alu_op = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_op = ALUOP_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMWR: begin
        IorD = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        PCSrc = 2'b01;
        branch = 1'b1;
        alu_op = ALUOP_SUB;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op(alu_op),
    .funct(Funct),
    .alu_control(ALUControl)
  );
  // Write enables are masked while reset is high so an aborted instruction cannot commit
  assign MemWrite = mem_write & ~reset;
  assign IRWrite = ir_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign PCEn = ~reset & (pc_write | (branch & Zero));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign Illegal = state_q == S_TRAP;
`else
  assign Illegal = 1'b0;
`endif
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: self-checking bench comparing every control output, cycle by cycle,
// against an instruction-level model of the multi-cycle sequence (honours MC_CTRL_ILLEGAL_TRAP_EN).
module tb_mips_mc_control;
  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl;
  logic [16:0] outs;
  int errors = 0, checks = 0;
  localparam logic [16:0] RESET_VEC = 17'b0_0_0_0_0_0_0_01_00_0010_0_0;
  logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  always #5 clk = ~clk;
  mips_mc_control dut (
    .clk(clk), .reset(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .PCEn(PCEn), .Illegal(Illegal)
  );
  assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, ALUControl, PCEn, Illegal};
  function automatic logic bad_insn(input logic [5:0] op, input logic [5:0] fn);
    logic op_ok, fn_ok;
    op_ok = op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
            op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    fn_ok = fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
            fn == 6'b100101 || fn == 6'b101010;
    return !op_ok || (op == 6'b000000 && !fn_ok);
  endfunction
  function automatic int cpi(input logic [5:0] op, input logic [5:0] fn);
    if (bad_insn(op, fn)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      return 22;
`else
      return 2;
`endif
    end
    return op == 6'b100011 ? 5 : (op == 6'b000100 || op == 6'b000010) ? 3 : 4;
  endfunction
  // Expected outputs in cycle k (0 = fetch) of an instruction
  function automatic logic [16:0] exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input int k);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen = 0, ill = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [3:0] ac = 0;
    if (k == 0) begin
      irw = 1; sb = 2'b01; ac = 4'b0010; pcen = 1;
    end else if (k == 1) begin
      sb = 2'b11; ac = 4'b0010;
    end else if (bad_insn(op, fn)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ill = 1;
`endif
    end else if (op == 6'b100011 || op == 6'b101011) begin
      if (k == 2) begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      else if (k == 3) begin iord = 1; mw = op == 6'b101011; end
      else begin m2r = 1; rw = 1; end
    end else if (op == 6'b000000) begin
      if (k == 2) begin
        sa = 1;
        ac = fn == 6'b100000 ? 4'b0010 : fn == 6'b100010 ? 4'b0110 :
             fn == 6'b100100 ? 4'b0000 : fn == 6'b100101 ? 4'b0001 : 4'b0111;
      end else begin rd = 1; rw = 1; end
    end else if (op == 6'b000100) begin
      sa = 1; ac = 4'b0110; ps = 2'b01; pcen = z;
    end else if (op == 6'b001000) begin
      if (k == 2) begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      else rw = 1;
    end else begin
      ps = 2'b10; pcen = 1;
    end
    return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, ac, pcen, ill};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (outs !== RESET_VEC) begin errors++; $display("FAIL reset_init got=%b exp=%b", outs, RESET_VEC); end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== exp_vec(0, 0, 0, 0)) begin errors++; $display("FAIL reset_first_fetch got=%b exp=%b", outs, exp_vec(0, 0, 0, 0)); end
    Op = 6'b100011;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL reset_lw_k%0d got=%b exp=%b", k, outs, exp_vec(Op, Funct, Zero, k)); end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (outs !== RESET_VEC) begin errors++; $display("FAIL reset_async_memrd got=%b exp=%b", outs, RESET_VEC); end
    step();
    checks++;
    if (outs !== RESET_VEC) begin errors++; $display("FAIL reset_held got=%b exp=%b", outs, RESET_VEC); end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, exp_vec(Op, Funct, Zero, 0)); end
    for (int k = 1; k < 5; k++) begin
      step();
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL reset_restart_k%0d got=%b exp=%b", k, outs, exp_vec(Op, Funct, Zero, k)); end
    end
    step();
  endtask
  task automatic test_lw();
    Op = 6'b100011;
    Funct = 6'($urandom);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL lw_k%0d got=%b exp=%b", k, outs, exp_vec(Op, Funct, Zero, k)); end
      step();
    end
    checks++;
    if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL lw_cycle6_fetch got=%b exp=%b", outs, exp_vec(Op, Funct, Zero, 0)); end
  endtask
  task automatic test_rtype();
    logic [5:0] fns [3] = '{6'b100010, 6'b101010, 6'b100100};
    foreach (fns[i]) begin
      Op = 6'b000000;
      Funct = fns[i];
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL rtype_%b_k%0d got=%b exp=%b", Funct, k, outs, exp_vec(Op, Funct, Zero, k)); end
        step();
      end
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL rtype_%b_cpi got=%b exp=%b", Funct, outs, exp_vec(Op, Funct, Zero, 0)); end
    end
  endtask
  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      Op = 6'b000100;
      Zero = 1'(z);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL beq_z%0d_k%0d got=%b exp=%b", z, k, outs, exp_vec(Op, Funct, Zero, k)); end
        if (k == 2) begin
          Zero = ~Zero;
          #1;
          checks++;
          if (PCEn !== Zero) begin errors++; $display("FAIL beq_late_zero got=%b exp=%b", PCEn, Zero); end
        end
        step();
      end
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL beq_z%0d_cpi got=%b exp=%b", z, outs, exp_vec(Op, Funct, Zero, 0)); end
    end
    Zero = 1'b0;
  endtask
  task automatic test_sw_j();
    logic [5:0] ops [2] = '{6'b101011, 6'b000010};
    foreach (ops[i]) begin
      Op = ops[i];
      for (int k = 0; k < cpi(Op, Funct); k++) begin
        checks++;
        if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL swj_%b_k%0d got=%b exp=%b", Op, k, outs, exp_vec(Op, Funct, Zero, k)); end
        step();
      end
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL swj_%b_cpi got=%b exp=%b", Op, outs, exp_vec(Op, Funct, Zero, 0)); end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      Op = legal_ops[$urandom_range(0, 5)];
      Funct = legal_fns[$urandom_range(0, 4)];
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 5) == 0) begin
        Op = 6'($urandom);
        Funct = 6'($urandom);
      end
`endif
      for (int k = 0; k < cpi(Op, Funct); k++) begin
        Zero = 1'($urandom);
        #1;
        checks++;
        if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL rand%0d_op%b_fn%b_k%0d got=%b exp=%b", n, Op, Funct, k, outs, exp_vec(Op, Funct, Zero, k)); end
        step();
      end
    end
    checks++;
    if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL rand_end_fetch got=%b exp=%b", outs, exp_vec(Op, Funct, Zero, 0)); end
  endtask
  task automatic test_illegal();
    logic [5:0] bad_ops [2] = '{6'b111111, 6'b000000};
    logic [5:0] bad_fns [2] = '{6'b000000, 6'b111111};
    foreach (bad_ops[i]) begin
      Op = bad_ops[i];
      Funct = bad_fns[i];
      for (int k = 0; k < cpi(Op, Funct); k++) begin
        checks++;
        if (outs !== exp_vec(Op, Funct, Zero, k)) begin errors++; $display("FAIL illegal%0d_k%0d got=%b exp=%b", i, k, outs, exp_vec(Op, Funct, Zero, k)); end
        step();
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== RESET_VEC) begin errors++; $display("FAIL trap_clear%0d got=%b exp=%b", i, outs, RESET_VEC); end
      step();
      rst = 1'b0;
      #1;
`endif
      checks++;
      if (outs !== exp_vec(Op, Funct, Zero, 0)) begin errors++; $display("FAIL illegal%0d_exit got=%b exp=%b", i, outs, exp_vec(Op, Funct, Zero, 0)); end
    end
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_j();
    test_random();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
